// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: rotates a single low row, debounces press and release.
// Accepted press updates key_code and pulses key_valid for one cycle; key_held spans press and release debounce.
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 256,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] keypad_rows,
    input  logic [3:0] keypad_cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_CYCLES) + 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    row_idx, row_nxt;
    logic [1:0]    col_idx, col_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    code_nxt;
    logic          valid_nxt;
    logic [3:0]    cols_s1, cols_s2;
    logic          col_bit;
    logic          any_low;

    function automatic logic [1:0] low_col(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'hE;
            4'd13:   return 4'h0;
            4'd14:   return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    assign keypad_rows = ~(4'b0001 << row_idx);
    assign key_held    = (state == HELD) || (state == RELEASE);
    assign col_bit     = cols_s2[col_idx];
    assign any_low     = (cols_s2 != 4'hF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            dwell     <= '0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            cols_s1   <= 4'h0;
            cols_s2   <= 4'h0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_nxt;
            col_idx   <= col_nxt;
            dwell     <= dwell_nxt;
            cnt       <= cnt_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            cols_s1   <= keypad_cols;
            cols_s2   <= cols_s1;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_idx;
        col_nxt   = col_idx;
        dwell_nxt = dwell;
        cnt_nxt   = cnt;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (any_low) begin
                        col_nxt   = low_col(cols_s2);
                        cnt_nxt   = '0;
                        state_nxt = DEBOUNCE;
                    end else begin
                        row_nxt = row_idx + 2'd1;
                    end
                end else begin
                    dwell_nxt = dwell + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (cnt == DB_LAST) begin
                    code_nxt  = key_map(row_idx, col_idx);
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = HELD;
                end else if (col_bit) begin
                    // Bounce: resume the same row from a fresh dwell.
                    cnt_nxt   = '0;
                    dwell_nxt = '0;
                    state_nxt = SCAN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HELD: begin
                if (col_bit) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (any_low) begin
                    cnt_nxt   = '0;
                    state_nxt = HELD;
                end else if (cnt == DB_LAST) begin
                    cnt_nxt   = '0;
                    dwell_nxt = '0;
                    row_nxt   = row_idx + 2'd1;
                    state_nxt = SCAN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_CYCLES, default 256, clk cycles each row is driven before advancing (min 4).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 480000 (20 ms at 24 MHz), consecutive stable cycles required for press or release (min 2).
REQ-003 The block SHALL have port clk, input, 1, system clock (24 MHz HSOSC).
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 The block SHALL have port keypad_rows, output, 4, row drive; exactly one bit low at all times.
REQ-006 The block SHALL have port keypad_cols, input, 4, column sense; pulled up, low = key closed; asynchronous to clk.
REQ-007 The block SHALL have port key_code, output, 4, hex value of the last accepted key.
REQ-008 The block SHALL have port key_valid, output, 1, single-cycle pulse per accepted press.
REQ-009 The block SHALL have port key_held, output, 1, high while an accepted key is still pressed or its release is being debounced.

Function
REQ-010 keypad_cols SHALL pass through a 2-flop synchronizer before any use; "cols" below means the synchronized value.
REQ-011 The key map SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D. Columns are indexed col0..col3 left to right.
REQ-012 The FSM SHALL have states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 In SCAN, a dwell counter SHALL count 0..SCAN_CYCLES-1. At terminal count the active row SHALL rotate row0->row1->row2->row3->row0 and the counter SHALL wrap to 0.
REQ-014 In SCAN, cols SHALL be sampled only at dwell terminal count. If any bit is low, the FSM SHALL latch the row and the lowest-index low column, hold the row (no rotation), and enter DEBOUNCE.
REQ-015 In DEBOUNCE, the row SHALL be frozen and a counter SHALL increment each cycle the latched column bit is low.
REQ-016 In DEBOUNCE, if the latched column bit is high in any cycle, the FSM SHALL return to SCAN with dwell counter 0 and the same row, with no output change.
REQ-017 When the DEBOUNCE count reaches DEBOUNCE_CYCLES, on the next clk:
  - key_code SHALL update to the mapped value;
  - key_valid SHALL pulse high for exactly one cycle;
  - the FSM SHALL enter HELD.
REQ-018 In HELD, key_held SHALL be 1 and the row SHALL be frozen; the FSM SHALL stay while the latched column bit is low and enter RELEASE when it goes high.
REQ-019 In RELEASE, a counter SHALL count consecutive cycles where all cols are high.
  - Any low bit SHALL return the FSM to HELD, with no new key_valid.
  - At DEBOUNCE_CYCLES the FSM SHALL enter SCAN on the next row with dwell counter 0, and key_held SHALL drop.
REQ-020 Other columns pressed during DEBOUNCE or HELD SHALL be ignored. Only the latched column governs press acceptance and the HELD->RELEASE exit.
REQ-021 key_code SHALL hold its value until the next accepted press. key_valid SHALL never assert in two consecutive cycles.
REQ-022 Counters SHALL be sized to $clog2 of their terminal values plus 1 and SHALL never overflow or wrap inside DEBOUNCE or RELEASE.

Reset
REQ-023 While reset is low, the block SHALL hold: state SCAN, keypad_rows = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0, all counters and synchronizer flops 0.
REQ-024 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL abort immediately to the REQ-023 values, and no key_valid SHALL be emitted.
REQ-025 After reset deasserts, scanning SHALL begin at row0 with dwell counter 0.

Verification
REQ-026 The bench SHALL use SCAN_CYCLES = 4, DEBOUNCE_CYCLES = 8 and cover the following directed scenarios:
  - Idle, cols = 4'b1111 -> keypad_rows cycles 1110, 1101, 1011, 0111, changing every 4 clk; key_valid never asserts.
  - Hold col1 low while row1 is active, for 30 clk -> exactly one key_valid pulse, key_code = 4'h5, key_held = 1 until 8 clk after release.
  - Col0 low for 5 clk, then high (bounce) in row3 -> return to SCAN, no key_valid, key_code unchanged, row3 continues to be driven.
  - Cols = 4'b1010 in row0 -> lowest index col0 latched -> key_code = 4'h1.
  - Release glitch: in RELEASE after key 4'hD, col3 low for 1 clk at count 5 -> back to HELD, no second key_valid; a clean release then resumes SCAN at row0.
  - Assert reset during HELD -> keypad_rows = 1110, key_held = 0, key_code = 0, all immediately.
